// File: rtl/kernel_loader.sv
// Kernel memory loader: reads DRAM words and unpacks them into rows of a selected kernel memory.
// One read is outstanding at a time, and each word supplies up to floor(DRAM_DATA_BITS/KER_WIDTH) rows.
module kernel_loader #(
   parameter int unsigned KER_NUM        = 3,
   parameter int unsigned KER_WIDTH      = 75,
   parameter int unsigned KER_ADDR_BITS  = 11,
   parameter int unsigned DRAM_DATA_BITS = 512,
   parameter int unsigned DRAM_ADDR_BITS = 29
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [1:0]                cfg_sel,
   input  logic [DRAM_ADDR_BITS-1:0] cfg_addr,
   input  logic [KER_ADDR_BITS:0]    cfg_rows,
   output logic                      busy,
   output logic                      done,
   output logic                      error,
   output logic                      dram_rd_req,
   output logic [DRAM_ADDR_BITS-1:0] dram_rd_addr,
   input  logic                      dram_rd_ack,
   input  logic                      dram_rd_valid,
   input  logic [DRAM_DATA_BITS-1:0] dram_rd_data,
   output logic [KER_NUM-1:0]        ker_wr_en,
   output logic [KER_ADDR_BITS-1:0]  ker_wr_addr,
   output logic [KER_WIDTH-1:0]      ker_wr_data
);

   localparam int unsigned ROWS_PER_WORD = DRAM_DATA_BITS / KER_WIDTH;
   localparam int unsigned USED_BITS     = ROWS_PER_WORD * KER_WIDTH;
   localparam int unsigned K_W           = (ROWS_PER_WORD > 1) ? $clog2(ROWS_PER_WORD) : 1;
   localparam int unsigned CNT_W         = KER_ADDR_BITS + 1;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, FIN} state_t;

   state_t                    state_q, state_d;
   logic [1:0]                sel_q, sel_d;
   logic [DRAM_ADDR_BITS-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]          rows_q, rows_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [K_W-1:0]            k_q, k_d;
   logic [DRAM_DATA_BITS-1:0] word_q, word_d;
   logic                      err_q, err_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      req_q, req_d;
   logic [KER_NUM-1:0]        wr_en_q, wr_en_d;
   logic [KER_ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
   logic [KER_WIDTH-1:0]      wr_data_q, wr_data_d;
   logic [KER_WIDTH-1:0]      row_data;

   // Next state; outputs are derived from the next-state values so they line up with the state.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      addr_d   = addr_q;
      rows_d   = rows_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      word_d   = word_q;
      err_d    = err_q;
      row_data = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d   = cfg_sel;
               addr_d  = cfg_addr;
               rows_d  = cfg_rows;
               cnt_d   = '0;
               k_d     = '0;
               err_d   = !(32'(cfg_sel) < KER_NUM);
               state_d = REQ;
            end
         end
         REQ: begin
            // Empty or invalid loads pass through here without ever raising a request.
            if ((rows_q == '0) || !(32'(sel_q) < KER_NUM)) begin
               state_d = FIN;
            end else if (req_q && dram_rd_ack) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dram_rd_valid) begin
               word_d  = dram_rd_data;
               k_d     = '0;
               state_d = UNPACK;
            end
         end
         UNPACK: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == rows_q) begin
               state_d = FIN;
            end else if (k_q == K_W'(ROWS_PER_WORD - 1)) begin
               k_d     = '0;
               addr_d  = addr_q + DRAM_ADDR_BITS'(1);
               state_d = REQ;
            end else begin
               k_d = k_q + K_W'(1);
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      for (int unsigned r = 0; r < ROWS_PER_WORD; r++) begin
         if (k_d == K_W'(r)) row_data = word_d[r*KER_WIDTH +: KER_WIDTH];
      end

      busy_d    = (state_d == REQ) || (state_d == WAIT) || (state_d == UNPACK);
      done_d    = (state_d == FIN);
      req_d     = (state_d == REQ) && (rows_d != '0) && (32'(sel_d) < KER_NUM);
      wr_en_d   = '0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (state_d == UNPACK) begin
         wr_en_d   = KER_NUM'(1) << sel_d;
         wr_addr_d = cnt_d[KER_ADDR_BITS-1:0];
         wr_data_d = row_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         addr_q    <= '0;
         rows_q    <= '0;
         cnt_q     <= '0;
         k_q       <= '0;
         word_q    <= '0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         req_q     <= 1'b0;
         wr_en_q   <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         rows_q    <= rows_d;
         cnt_q     <= cnt_d;
         k_q       <= k_d;
         word_q    <= word_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         req_q     <= req_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Bits above the last whole row are captured but never unpacked.
   if (USED_BITS < DRAM_DATA_BITS) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^word_q[DRAM_DATA_BITS-1:USED_BITS];
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = err_q;
   assign dram_rd_req  = req_q;
   assign dram_rd_addr = addr_q;
   assign ker_wr_en    = wr_en_q;
   assign ker_wr_addr  = wr_addr_q;
   assign ker_wr_data  = wr_data_q;

endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- KER_NUM, 3, number of kernel memories
- KER_WIDTH, 75, kernel memory row width in bits
- KER_ADDR_BITS, 11, kernel row address width (covers height 1920)
- DRAM_DATA_BITS, 512, DRAM word width
- DRAM_ADDR_BITS, 29, DRAM word address width
REQ-002 The module SHALL have one clock and an asynchronous, active-low reset, with ports (name, direction, width, meaning):
- clk, in, 1, sole clock, all logic on its rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle load request
- cfg_sel, in, 2, target kernel memory index
- cfg_addr, in, DRAM_ADDR_BITS, first DRAM word address
- cfg_rows, in, KER_ADDR_BITS+1, number of rows to load
- busy, out, 1, load in progress
- done, out, 1, one-cycle completion pulse
- error, out, 1, sticky flag: invalid cfg_sel; cleared by next accepted start
- dram_rd_req, out, 1, read request, held until acknowledged
- dram_rd_addr, out, DRAM_ADDR_BITS, read word address
- dram_rd_ack, in, 1, request accepted this cycle
- dram_rd_valid, in, 1, read data valid
- dram_rd_data, in, DRAM_DATA_BITS, read data
- ker_wr_en, out, KER_NUM, one-hot kernel memory write enable
- ker_wr_addr, out, KER_ADDR_BITS, kernel row address
- ker_wr_data, out, KER_WIDTH, kernel row data

Function
REQ-003 The module SHALL implement the FSM states IDLE, REQ, WAIT, UNPACK and FIN.
REQ-004 In IDLE with start=1, the module SHALL latch cfg_*, clear error, set busy=1 the next cycle, and go to REQ.
REQ-005 A start received while busy=1 SHALL be ignored, with no change to state or latched configuration.
REQ-006 In REQ, dram_rd_req SHALL be 1 with a stable dram_rd_addr until dram_rd_ack=1; on ack the module SHALL go to WAIT, with at most one read outstanding.
REQ-007 dram_rd_req SHALL assert the cycle after start is accepted (latency 1).
REQ-008 In WAIT, dram_rd_valid=1 SHALL capture dram_rd_data into a 512-bit register and go to UNPACK.
REQ-009 dram_rd_valid outside WAIT SHALL be ignored.
REQ-010 ROWS_PER_WORD SHALL be floor(DRAM_DATA_BITS/KER_WIDTH) (6 at default); row k of a word SHALL be bits [KER_WIDTH*k+KER_WIDTH-1 : KER_WIDTH*k], and the upper 62 bits SHALL be discarded.
REQ-011 In UNPACK, the module SHALL write one row per cycle: ker_wr_en[cfg_sel]=1, ker_wr_addr = rows written so far (starting at 0), ker_wr_data = row k.
REQ-012 After row 5, or after the final row, UNPACK SHALL go to REQ with dram_rd_addr+1 if rows remain, otherwise to FIN.
REQ-013 The final word SHALL write only the remaining (cfg_rows mod 6, or 6) rows; unused rows SHALL NOT be written.
REQ-014 dram_rd_addr SHALL wrap modulo 2^DRAM_ADDR_BITS.
REQ-015 FIN SHALL pulse done=1 for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-016 With cfg_rows=0, the module SHALL go directly to FIN with no DRAM request and no write.
REQ-017 With cfg_sel>=KER_NUM, the module SHALL set error=1 and go directly to FIN with no DRAM request and no write.
REQ-018 ker_wr_en SHALL be all-zero in every state except UNPACK.

Reset
REQ-019 While rst_n=0, the module SHALL hold the FSM in IDLE, busy=0, done=0, error=0, dram_rd_req=0, dram_rd_addr=0, ker_wr_en=0, ker_wr_addr=0, ker_wr_data=0, and all counters at 0.
REQ-020 Reset asserted mid-load SHALL abort immediately; a dram_rd_valid arriving after reset release SHALL be ignored because the FSM is in IDLE.

Verification
REQ-021 The bench SHALL cover: cfg_sel=1, cfg_addr=0x100, cfg_rows=6, ack and valid 3 cycles later -> one request at 0x100, 6 writes to ker_wr_en=3'b010 at addresses 0..5 carrying data slices 0..5, done 1 cycle after the last write.
REQ-022 The bench SHALL cover: cfg_rows=14 -> requests at addr, addr+1, addr+2; writes 6+6+2 at addresses 0..13; exactly 14 write cycles.
REQ-023 The bench SHALL cover: cfg_rows=0, and separately cfg_sel=3 -> done 2 cycles after start, no dram_rd_req, no ker_wr_en; error=1 only for cfg_sel=3, cleared by the next start.
REQ-024 The bench SHALL cover: cfg_addr=0x1FFFFFFF, cfg_rows=7 -> second request at address 0x0.
REQ-025 The bench SHALL cover: start pulsed during a load, and ack delayed 10 cycles -> no reconfiguration, dram_rd_req and dram_rd_addr held stable until ack.
REQ-026 The bench SHALL cover: rst_n low for 1 cycle in WAIT, then valid -> all outputs at reset values, no writes, busy=0.
